// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and widths for the RAM-port to Wishbone-classic bridge.
package mem_bus_bridge_pkg;

    localparam int RegBus = 32;
    localparam int SelW   = 4;
    localparam int StallW = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        BUSY       = 2'b01,
        WAIT_STALL = 2'b11
    } state_e;

endpackage

// File: rtl/mem_bus_bridge.sv
// Core data port to registered Wishbone-classic master with stall request.
// Optional BUS_TIMEOUT_EN adds an 8-bit BUSY watchdog and sticky bus_err_o.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int STALL_IDX      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [StallW-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic [RegBus-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    input  logic [SelW-1:0]   cpu_sel_i,
    input  logic [RegBus-1:0] cpu_data_i,
    output logic [RegBus-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic [RegBus-1:0] wb_adr_o,
    output logic [RegBus-1:0] wb_dat_o,
    output logic [SelW-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
`ifdef BUS_TIMEOUT_EN
    output logic              bus_err_o,
`endif
    input  logic [RegBus-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    state_e            state_q;
    logic [RegBus-1:0] adr_q;
    logic [RegBus-1:0] dat_q;
    logic [RegBus-1:0] rd_buf_q;
    logic [SelW-1:0]   sel_q;
    logic              we_q;
    logic              cyc_q;
    logic              stb_q;
    logic              stall_own;
    logic              tmo_hit;
    logic              unused_stall;

    assign stall_own    = stall_i[STALL_IDX];
    assign unused_stall = ^stall_i;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       err_q;

    assign tmo_hit   = (state_q == BUSY) && (cnt_q == TmoLast);
    assign bus_err_o = err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            rd_buf_q <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        adr_q   <= cpu_addr_i;
                        dat_q   <= cpu_data_i;
                        sel_q   <= cpu_sel_i;
                        we_q    <= cpu_we_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= BUSY;
`ifdef BUS_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (wb_ack_i) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        we_q     <= 1'b0;
                        sel_q    <= '0;
                        rd_buf_q <= wb_dat_i;
                        state_q  <= stall_own ? WAIT_STALL : IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                WAIT_STALL: begin
                    // Hold off re-issue until the owning stage is released.
                    if (!stall_own || flush_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            IDLE: stallreq_o = cpu_ce_i & ~flush_i;
            BUSY: begin
                if (!flush_i) begin
                    if (wb_ack_i) cpu_data_o = wb_dat_i;
                    else          stallreq_o = ~tmo_hit;
                end
            end
            WAIT_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Converts the core's single-cycle RAM-style data port (addr/we/sel/data/ce) into a registered Wishbone-classic master transaction, and raises a pipeline stall request while the transfer is outstanding.
- Sits directly downstream of the core's MEM-stage data port; one instance per port.
- Instruction and data ports use separate instances.
- Returns read data to the core in the cycle the transfer completes, and holds it while the pipeline stays stalled.

Parameters:
- STALL_IDX, 4: bit of stall_i belonging to the stage that owns this port (1 = IF, 4 = MEM).
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before an aborted transfer; used only with BUS_TIMEOUT_EN; 8-bit counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  6  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush; aborts any transfer.
- cpu_ce_i  in  1  core requests an access.
- cpu_addr_i  in  32  byte address.
- cpu_we_i  in  1  1 = write.
- cpu_sel_i  in  4  byte lanes.
- cpu_data_i  in  32  write data.
- cpu_data_o  out  32  read data to core.
- stallreq_o  out  1  stall request to ctrl.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  bus write data.
- wb_sel_o  out  4  bus byte select.
- wb_we_o  out  1  bus write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge.
- bus_err_o  out  1  sticky timeout flag; exists only with BUS_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All wb_* outputs = 0.
  - rd_buf = 0.
  - cpu_data_o = 0, stallreq_o = 0, bus_err_o = 0.
- States: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register addr/data/sel/we onto the wb_* outputs, set cyc=stb=1, go to BUSY.
  - The bus therefore sees the request 1 cycle after cpu_ce_i.
  - stallreq_o = cpu_ce_i & ~flush_i (combinational), so the core freezes in the request cycle.
- BUSY:
  - wb_* outputs are held stable until ack.
  - stallreq_o = ~wb_ack_i.
  - On wb_ack_i=1:
    - Clear cyc/stb/we/sel; rd_buf <= wb_dat_i.
    - Drive cpu_data_o = wb_dat_i combinationally in that cycle.
    - If stall_i[STALL_IDX]=1, go to WAIT_STALL; else go to IDLE.
  - flush_i=1 (with or without ack): clear cyc/stb, go to IDLE, stallreq_o = 0, rd_buf unchanged.
- WAIT_STALL:
  - cpu_data_o = rd_buf; stallreq_o = 0.
  - Go to IDLE when stall_i[STALL_IDX]=0 or flush_i=1.
  - This prevents a re-issue while another stage holds the pipeline.
- cpu_data_o outside the cases above = 0.
- Writes: cpu_data_o is irrelevant but follows the same rules.
- Back-to-back accesses: the earliest new request is the cycle after returning to IDLE. Minimum 3 cycles per access with 1-cycle ack (request, BUSY, ack).
- Ack while in IDLE or WAIT_STALL is ignored.
- Addresses pass unmodified; no alignment check.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - An 8-bit counter counts BUSY cycles.
  - At TIMEOUT_CYCLES without ack: abort (cyc/stb=0), set bus_err_o=1 (sticky until rst), return cpu_data_o = 32'h0000_0000 for one cycle with stallreq_o=0, go to IDLE.
  - The counter clears on entering BUSY.
- Not defined: no counter and no bus_err_o port; BUSY waits indefinitely.

Decomposition:
- Shared package/defines header:
  - State encodings (IDLE=2'b00, BUSY=2'b01, WAIT_STALL=2'b11).
  - Widths RegBus (32) and sel (4).
  - Stall vector width (6).
- No sub-module; the timeout counter stays inline.

Test Plan:
- Read, ack 2 cycles after stb: cpu_ce_i=1, addr=0x100, wb_dat_i=0xDEADBEEF.
  - Expect stallreq_o=1 for 3 cycles.
  - Expect cpu_data_o=0xDEADBEEF in the ack cycle, cyc=0 after it.
- Write with byte lanes: addr=0x20, sel=4'b0011, data=0x1234ABCD.
  - Expect wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x1234ABCD stable until ack; then IDLE.
- Ack while stall_i[4] held by another source for 4 cycles.
  - Expect WAIT_STALL, cpu_data_o=rd_buf for all 4 cycles, no second stb.
- flush_i=1 mid-BUSY.
  - Expect cyc/stb drop next edge, stallreq_o=0 immediately, later ack ignored.
- Assert rst during BUSY.
  - Expect all outputs 0 asynchronously; after release, a new request starts cleanly.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack.
  - Expect abort after 8 BUSY cycles and bus_err_o=1 staying set.
